// File: rtl/bridge_arb_pkg.sv
// Shared types and constants for the bridge stream arbiter.
package bridge_arb_pkg;
  typedef enum logic [1:0] {IDLE, ARB, LOCK} arb_state_t;
  localparam int PKT_CNT_W = 16;
endpackage

// File: rtl/bridge_stream_arbiter_if.sv
// Requester-side and bridge-side stream signals of the arbiter.
interface bridge_stream_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DIN_W   = 32,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                          req_vld_i;
  logic [NUM_REQ-1:0][DIN_W-1:0][DATA_W-1:0]   req_din;
  logic [NUM_REQ-1:0]                          req_last_i;
  logic [NUM_REQ-1:0]                          req_rdy_o;
  logic                                        vld_o;
  logic [DIN_W-1:0][DATA_W-1:0]                dout;
  logic                                        last_o;
  logic                                        rdy_i;
  logic [ID_W-1:0]                             grant_id_o;
  logic                                        busy_o;

  modport slave (
    input  req_vld_i, req_din, req_last_i, rdy_i,
    output req_rdy_o, vld_o, dout, last_o, grant_id_o, busy_o
  );
  modport master (
    output req_vld_i, req_din, req_last_i, rdy_i,
    input  req_rdy_o, vld_o, dout, last_o, grant_id_o, busy_o
  );
endinterface

// File: rtl/bridge_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               any_o
);
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    gnt_id_o = '0;
    sum      = '0;
    idx      = '0;
    any_o    = |req_i;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (req_i[idx]) gnt_id_o = idx;
    end
  end
endmodule

// File: rtl/bridge_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding one stream bridge.
// Optional BRIDGE_ARB_PKT_CNT_EN adds per-requester completed-packet counters.
module bridge_stream_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIN_W   = 32,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst_n,
  bridge_stream_arbiter_if.slave bus
`ifdef BRIDGE_ARB_PKT_CNT_EN
  ,
  output logic [NUM_REQ-1:0][PKT_CNT_W-1:0] pkt_cnt_o
`endif
);
  arb_state_t                   state_q, state_d;
  logic [ID_W-1:0]              rr_q, rr_d, grant_q, grant_d, pick_id;
  logic                         pick_any, vld, last, fire;
  logic [NUM_REQ-1:0]           rdy;
  logic [DIN_W-1:0][DATA_W-1:0] dout;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_i    (bus.req_vld_i),
    .ptr_i    (rr_q),
    .gnt_id_o (pick_id),
    .any_o    (pick_any)
  );

  assign fire = (state_q == LOCK) & bus.req_vld_i[grant_q] & bus.rdy_i
              & bus.req_last_i[grant_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    vld     = 1'b0;
    last    = 1'b0;
    rdy     = '0;
    case (state_q)
      IDLE: if (|bus.req_vld_i) state_d = ARB;
      ARB: begin
        // Requests may be withdrawn between IDLE and ARB; keep the old grant then.
        if (pick_any) begin
          grant_d = pick_id;
          state_d = LOCK;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        vld          = bus.req_vld_i[grant_q];
        last         = bus.req_last_i[grant_q];
        rdy[grant_q] = bus.rdy_i;
        if (fire) begin
          rr_d    = (grant_q == ID_W'(NUM_REQ-1)) ? '0 : grant_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data follows the registered grant even when no beat is offered.
  assign dout           = bus.req_din[grant_q];
  assign bus.dout       = dout;
  assign bus.vld_o      = vld;
  assign bus.last_o     = last;
  assign bus.req_rdy_o  = rdy;
  assign bus.grant_id_o = grant_q;
  assign bus.busy_o     = (state_q == LOCK);

`ifdef BRIDGE_ARB_PKT_CNT_EN
  logic [NUM_REQ-1:0][PKT_CNT_W-1:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pkt_cnt_q <= '0;
    else if (fire) pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + PKT_CNT_W'(1);
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_bridge_stream_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, random vs. model.
module tb_bridge_stream_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bridge_stream_arbiter_if #(.NUM_REQ(N), .DIN_W(DW), .DATA_W(EW)) bus ();

`ifdef BRIDGE_ARB_PKT_CNT_EN
  logic [N-1:0][15:0] pkt_cnt;
`endif

  bridge_stream_arbiter #(.NUM_REQ(N), .DIN_W(DW), .DATA_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRIDGE_ARB_PKT_CNT_EN
    ,
    .pkt_cnt_o (pkt_cnt)
`endif
  );

  typedef struct {
    logic [3:0] v, l;
    logic       r;
    logic       e_vld, e_last;
    logic [3:0] e_rdy;
    int         e_gid;
    logic       e_busy;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int i);
    logic [7:0] b;
    b = 8'h11 * 8'(i + 1);
    return {32{b}};
  endfunction

  function automatic logic [8:0] pk(input logic v, input logic l, input logic [3:0] r,
                                    input int g, input logic b);
    return {v, l, r, 2'(g), b};
  endfunction

  function automatic logic [8:0] act_pk();
    return {bus.vld_o, bus.last_o, bus.req_rdy_o, bus.grant_id_o, bus.busy_o};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
    bus.req_vld_i  = v;
    bus.req_last_i = l;
    bus.rdy_i      = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fixed_data();
    for (int i = 0; i < N; i++) bus.req_din[i] = pat(i);
  endtask

  // Reference model: packet ownership plus a pending-arbitration flag.
  int m_owner, m_rr, m_gid;
  bit m_armed;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_gid = 0; m_armed = 0;
  endtask

  task automatic model_step(input logic [3:0] v, input logic [3:0] l, input logic r);
    if (m_owner >= 0) begin
      if (((v >> m_owner) & 4'd1) != 0 && r && ((l >> m_owner) & 4'd1) != 0) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (m_armed) begin
      m_armed = 0;
      for (int k = N-1; k >= 0; k--)
        if (((v >> ((m_rr + k) % N)) & 4'd1) != 0) begin
          m_gid = (m_rr + k) % N; m_owner = m_gid;
        end
    end else if (v != 0) begin
      m_armed = 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] v, l, er;
    logic       r;
    logic [3:0] sv [6];
    logic [3:0] sl [6];
    logic       se [6];

    drive(4'b0, 4'b0, 1'b0);
    fixed_data();
    #12;
    chk("reset_outputs", 256'(act_pk()), 256'(pk(0, 0, 4'b0, 0, 0)));
    step();
    rst_n = 1'b1;

    // Req0 3-beat packet, then req0+req1 contend with rr_ptr at 1.
    tbl[0] = '{4'b0001, 4'b0000, 1'b1, 0, 0, 4'b0000, 0, 0};
    tbl[1] = '{4'b0001, 4'b0000, 1'b1, 0, 0, 4'b0000, 0, 0};
    tbl[2] = '{4'b0001, 4'b0000, 1'b1, 1, 0, 4'b0001, 0, 1};
    tbl[3] = '{4'b0001, 4'b0000, 1'b1, 1, 0, 4'b0001, 0, 1};
    tbl[4] = '{4'b0001, 4'b0001, 1'b1, 1, 1, 4'b0001, 0, 1};
    tbl[5] = '{4'b0000, 4'b0000, 1'b1, 0, 0, 4'b0000, 0, 0};
    tbl[6] = '{4'b0011, 4'b0010, 1'b1, 0, 0, 4'b0000, 0, 0};
    tbl[7] = '{4'b0011, 4'b0010, 1'b1, 0, 0, 4'b0000, 0, 0};
    tbl[8] = '{4'b0011, 4'b0010, 1'b1, 1, 1, 4'b0010, 1, 1};
    tbl[9] = '{4'b0000, 4'b0000, 1'b1, 0, 0, 4'b0000, 1, 0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].r);
      @(negedge clk);
      chk($sformatf("table_ctl[%0d]", i), 256'(act_pk()),
          256'(pk(tbl[i].e_vld, tbl[i].e_last, tbl[i].e_rdy, tbl[i].e_gid, tbl[i].e_busy)));
      chk($sformatf("table_dout[%0d]", i), bus.dout, pat(tbl[i].e_gid));
      step();
    end

    // Reset mid-packet on req3; rr_ptr was 2 beforehand.
    drive(4'b1000, 4'b0000, 1'b1);
    step(); step();
    @(negedge clk);
    chk("req3_locked", 256'(act_pk()), 256'(pk(1, 0, 4'b1000, 3, 1)));
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_packet", 256'(act_pk()), 256'(pk(0, 0, 4'b0, 0, 0)));
    step();
    drive(4'b1111, 4'b1111, 1'b1);
    rst_n = 1'b1;

    // All requesters streaming single-beat packets.
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c % 3 == 2)
        chk($sformatf("rr_order[%0d]", c), 256'(act_pk()),
            256'(pk(1, 1, 4'(1 << ((c/3) % 4)), (c/3) % 4, 1)));
      else
        chk($sformatf("rr_gap[%0d]", c), 256'(act_pk()),
            256'(pk(0, 0, 4'b0, (c < 3) ? 0 : ((c/3) - 1) % 4, 0)));
      step();
    end

    // Req1 locked with a bubble while req2 waits.
    sv = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0110, 4'b0110};
    sl = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    se = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 6; c++) begin
      drive(sv[c], sl[c], 1'b1);
      @(negedge clk);
      chk($sformatf("bubble[%0d]", c), 256'(act_pk()),
          256'(pk(se[c], c == 5, (c >= 2) ? 4'b0010 : 4'b0000, (c >= 2) ? 1 : 0, c >= 2)));
      step();
    end

    // Req2 stalled by the bridge for 5 cycles.
    drive(4'b0100, 4'b0100, 1'b0);
    for (int c = 0; c < 9; c++) begin
      if (c == 7) bus.rdy_i = 1'b1;
      if (c == 8) drive(4'b0, 4'b0, 1'b1);
      @(negedge clk);
      if (c < 2)       chk("stall_setup", 256'(act_pk()), 256'(pk(0, 0, 4'b0, 1, 0)));
      else if (c < 7) begin
        chk($sformatf("stall_hold[%0d]", c), 256'(act_pk()), 256'(pk(1, 1, 4'b0, 2, 1)));
        chk($sformatf("stall_dout[%0d]", c), bus.dout, pat(2));
      end
      else if (c == 7) chk("stall_release", 256'(act_pk()), 256'(pk(1, 1, 4'b0100, 2, 1)));
      else             chk("stall_done", 256'(act_pk()), 256'(pk(0, 0, 4'b0, 2, 0)));
      step();
    end

`ifdef BRIDGE_ARB_PKT_CNT_EN
    rst_n = 1'b0; #1 rst_n = 1'b1;
    drive(4'b0100, 4'b0100, 1'b1);
    repeat (6) step();
    drive(4'b0, 4'b0, 1'b1);
    step();
    @(negedge clk);
    chk("pkt_cnt", 256'(pkt_cnt), 256'({16'd0, 16'd2, 16'd0, 16'd0}));
    step();
`endif

    // Randomised traffic against the reference model.
    rst_n = 1'b0; #1 rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++) bus.req_din[i] = {8{$urandom()}};
      v = 4'($urandom()) | 4'($urandom());
      l = 4'($urandom()) & 4'($urandom());
      r = ($urandom() % 4) != 0;
      drive(v, l, r);
      @(negedge clk);
      er = (m_owner >= 0 && r) ? 4'(1 << m_owner) : 4'b0;
      if (m_owner >= 0)
        chk($sformatf("rand_ctl[%0d]", cyc), 256'(act_pk()),
            256'(pk(v[m_owner[1:0]], l[m_owner[1:0]], er, m_gid, 1)));
      else
        chk($sformatf("rand_ctl[%0d]", cyc), 256'(act_pk()), 256'(pk(0, 0, 4'b0, m_gid, 0)));
      chk($sformatf("rand_dout[%0d]", cyc), bus.dout, bus.req_din[m_gid]);
      model_step(v, l, r);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bridge_stream_arbiter.md
BRIDGE_STREAM_ARBITER -- requirements
Module: bridge_stream_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester streams; legal range 2..16.
REQ-002 Parameter DIN_W, default 32: elements per beat; equals the DIN_W of the downstream combine bridge.
REQ-003 Parameter DATA_W, default 8: bits per element.
REQ-004 Parameter ID_W, default $clog2(NUM_REQ): width of the grant ID.
REQ-005 clk  input  1  rising-edge clock; the only clock.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_vld_i  input  [NUM_REQ]  per-requester beat valid.
REQ-008 req_din  input  [NUM_REQ][DIN_W][DATA_W]  per-requester beat data.
REQ-009 req_last_i  input  [NUM_REQ]  last beat of packet, per requester.
REQ-010 req_rdy_o  output  [NUM_REQ]  per-requester ready.
REQ-011 vld_o  output  1  beat valid toward the bridge.
REQ-012 dout  output  [DIN_W][DATA_W]  beat data toward the bridge.
REQ-013 last_o  output  1  packet end toward the bridge.
REQ-014 rdy_i  input  1  bridge ready.
REQ-015 grant_id_o  output  ID_W  index of the currently locked requester.
REQ-016 busy_o  output  1  high while a packet is locked.

Function
REQ-017 The FSM SHALL have states IDLE, ARB and LOCK.
REQ-018 IDLE: all req_rdy_o=0, vld_o=0; if any req_vld_i=1, go to ARB.
REQ-019 ARB: round-robin pick among asserted req_vld_i, starting at rr_ptr; register grant_id; go to LOCK; no handshake in this cycle.
REQ-020 If no req_vld_i is asserted in ARB (requests withdrawn), the FSM SHALL return to IDLE with no grant change.
REQ-021 LOCK: vld_o=req_vld_i[g], dout=req_din[g], last_o=req_last_i[g], req_rdy_o[g]=rdy_i; all other req_rdy_o=0 (combinational pass-through, zero added latency per beat).
REQ-022 The grant SHALL be held until a beat with vld_o&rdy_i&last_o completes; requester bubbles (vld low) mid-packet do not release the grant.
REQ-023 On the last-beat handshake: rr_ptr=(g+1) mod NUM_REQ; next state IDLE.
REQ-024 Packet start latency: first beat offered at vld_o 2 cycles after req_vld_i rises from IDLE.
REQ-025 A single-beat packet (last on first beat) SHALL be fully transferred, then the FSM returns to IDLE.
REQ-026 When vld_o=0, dout SHALL be driven with the granted requester's data (not zeroed); last_o SHALL be 0 outside LOCK.
REQ-027 grant_id_o SHALL show the registered grant; busy_o=1 exactly in LOCK.

Reset
REQ-028 On rst_n=0: state=IDLE, rr_ptr=0, grant_id=0; outputs vld_o=0, last_o=0, req_rdy_o=0, busy_o=0, grant_id_o=0.
REQ-029 Reset mid-packet SHALL abandon the packet; no recovery of partial state.

Configuration
REQ-030 Macro BRIDGE_ARB_PKT_CNT_EN: when defined, adds output pkt_cnt_o [NUM_REQ][16], a per-requester count of completed packets (incremented on the last-beat handshake, wraps at 2^16, reset 0).
REQ-031 Without BRIDGE_ARB_PKT_CNT_EN, the port and the counters SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package bridge_arb_pkg SHALL hold the arb_state_t enum (IDLE, ARB, LOCK) and the packet-counter width constant PKT_CNT_W=16.
REQ-033 Sub-module rr_pick SHALL be a combinational round-robin picker: inputs req[NUM_REQ] and ptr; outputs gnt_id and any.

Verification
REQ-034 Req0 only, a 3-beat packet, rdy_i=1 -> beats seen at vld_o in cycles 2,3,4; last_o on beat 3; grant_id_o=0; rr_ptr=1.
REQ-035 Req0..3 all valid, each sending 1-beat packets continuously -> grant order 0,1,2,3,0; each packet takes 3 cycles (IDLE, ARB, LOCK).
REQ-036 Req1 locked with a bubble mid-packet while req2 is valid -> grant stays 1 until last; req_rdy_o[2]=0 throughout.
REQ-037 rdy_i=0 for 5 cycles during LOCK -> vld_o and dout held stable; no beat lost; req_rdy_o[g]=0.
REQ-038 rst_n pulsed low mid-packet on req3 -> all outputs at reset values immediately; next grant from rr_ptr=0.
REQ-039 With BRIDGE_ARB_PKT_CNT_EN, two packets on req2 -> pkt_cnt_o[2]=2, all other counters 0.
